// File: rtl/sobel_pkg.sv
// Shared types and helpers for the streaming Sobel core: FSM states, gradient width, saturation.
package sobel_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Signed width that holds any Sobel gradient of an unsigned pix_w-bit image.
    function automatic int grad_w(input int pix_w);
        return pix_w + 3;
    endfunction

    function automatic logic [31:0] sat_u(input logic [31:0] v, input int pix_w);
        logic [31:0] mx;
        mx = (32'd1 << pix_w) - 32'd1;
        return (v > mx) ? mx : v;
    endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// Two-row line memory: row 0 holds the previous row, row 1 the one before it.
// Latency: combinational read at addr, write on the shift_en edge.
// Backpressure: nothing moves unless shift_en is high.
module sobel_line_buffer #(
    parameter int IMG_W = 640,
    parameter int PIX_W = 8,
    parameter int AW    = $clog2(IMG_W)
) (
    input  logic             clk,
    input  logic             shift_en,
    input  logic [AW-1:0]    addr,
    input  logic [PIX_W-1:0] wr_pix,
    output logic [PIX_W-1:0] rd_line0,
    output logic [PIX_W-1:0] rd_line1
);

    logic [PIX_W-1:0] line0_q [IMG_W];
    logic [PIX_W-1:0] line1_q [IMG_W];

    assign rd_line0 = line0_q[addr];
    assign rd_line1 = line1_q[addr];

    // Contents are never reset; the window is flagged invalid until both rows are filled.
    always_ff @(posedge clk) begin
        if (shift_en) begin
            line1_q[addr] <= line0_q[addr];
            line0_q[addr] <= wr_pix;
        end
    end

endmodule

// File: rtl/sobel_stream_core.sv
// Streaming 3x3 Sobel |gx|+|gy| core; SOBEL_THRESH_EN adds a thresh port and binary output.
// Latency: 2 cycles from pixel accept to out_valid (window, gradient, magnitude stages).
// Backpressure: out_valid && !out_ready freezes every stage and drops in_ready.
module sobel_stream_core
    import sobel_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int PIX_W = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic [PIX_W-1:0] in_pix,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [PIX_W-1:0] out_pix,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef SOBEL_THRESH_EN
    input  logic [PIX_W-1:0] thresh,
`endif
    output logic             busy,
    output logic             frame_done
);

    localparam int GW = grad_w(PIX_W);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    state_t                  state_q, state_d;
    logic [CW-1:0]           col_q, col_d;
    logic [RW-1:0]           row_q, row_d;
    logic [PIX_W-1:0]        win_q [3][3];
    logic [PIX_W-1:0]        win_d [3][3];
    logic                    s0_vld_q, s0_vld_d;
    logic signed [GW-1:0]    gx_q, gx_d, gy_q, gy_d;
    logic                    g_vld_q, g_vld_d;
    logic [PIX_W-1:0]        out_pix_q, out_pix_d;
    logic                    out_valid_q, out_valid_d;
    logic                    frame_done_q, frame_done_d;

    logic                    en, accept;
    logic [PIX_W-1:0]        rd_line0, rd_line1;
    logic [GW-1:0]           wz [3][3];
    logic [GW-1:0]           sum_l, sum_r, sum_t, sum_b;
    logic signed [GW-1:0]    gx_new, gy_new;
    logic [GW-1:0]           abs_gx, abs_gy, mag;
    logic [PIX_W-1:0]        mag_sat, res;

    assign en         = !out_valid_q || out_ready;
    assign in_ready   = en && (state_q == RUN);
    assign accept     = in_valid && in_ready;
    assign busy       = (state_q != IDLE);
    assign out_pix    = out_pix_q;
    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;

    sobel_line_buffer #(
        .IMG_W (IMG_W),
        .PIX_W (PIX_W),
        .AW    (CW)
    ) u_line_buffer (
        .clk      (clk),
        .shift_en (accept),
        .addr     (col_q),
        .wr_pix   (in_pix),
        .rd_line0 (rd_line0),
        .rd_line1 (rd_line1)
    );

    // Gradients from the current window, magnitude from the registered gradients.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                wz[r][c] = GW'(win_q[r][c]);
            end
        end
        sum_l  = wz[0][0] + (wz[1][0] << 1) + wz[2][0];
        sum_r  = wz[0][2] + (wz[1][2] << 1) + wz[2][2];
        sum_t  = wz[0][0] + (wz[0][1] << 1) + wz[0][2];
        sum_b  = wz[2][0] + (wz[2][1] << 1) + wz[2][2];
        gx_new = signed'(sum_r - sum_l);
        gy_new = signed'(sum_b - sum_t);
        abs_gx = gx_q[GW-1] ? unsigned'(-gx_q) : unsigned'(gx_q);
        abs_gy = gy_q[GW-1] ? unsigned'(-gy_q) : unsigned'(gy_q);
        mag    = abs_gx + abs_gy;
        mag_sat = PIX_W'(sat_u(32'(mag), PIX_W));
`ifdef SOBEL_THRESH_EN
        res = (mag_sat >= thresh) ? '1 : '0;
`else
        res = mag_sat;
`endif
    end

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        win_d        = win_q;
        s0_vld_d     = s0_vld_q;
        gx_d         = gx_q;
        gy_d         = gy_q;
        g_vld_d      = g_vld_q;
        out_pix_d    = out_pix_q;
        out_valid_d  = out_valid_q;
        frame_done_d = 1'b0;

        if (en) begin
            s0_vld_d = 1'b0;
            if (accept) begin
                for (int r = 0; r < 3; r++) begin
                    win_d[r][0] = win_q[r][1];
                    win_d[r][1] = win_q[r][2];
                end
                win_d[0][2] = rd_line1;
                win_d[1][2] = rd_line0;
                win_d[2][2] = in_pix;
                // Requiring col>=2 keeps windows from spanning a row wrap.
                s0_vld_d = (row_q >= RW'(2)) && (col_q >= CW'(2));
                if (col_q == COL_LAST) begin
                    col_d = '0;
                    row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
                end else begin
                    col_d = col_q + CW'(1);
                end
            end
            gx_d        = gx_new;
            gy_d        = gy_new;
            g_vld_d     = s0_vld_q;
            out_pix_d   = res;
            out_valid_d = g_vld_q;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = RUN;
                    col_d       = '0;
                    row_d       = '0;
                    s0_vld_d    = 1'b0;
                    g_vld_d     = 1'b0;
                    out_valid_d = 1'b0;
                end
            end
            RUN: begin
                if (accept && (col_q == COL_LAST) && (row_q == ROW_LAST)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_valid_q && out_ready && !g_vld_q && !s0_vld_q) begin
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= '0;
                end
            end
            s0_vld_q     <= 1'b0;
            gx_q         <= '0;
            gy_q         <= '0;
            g_vld_q      <= 1'b0;
            out_pix_q    <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            win_q        <= win_d;
            s0_vld_q     <= s0_vld_d;
            gx_q         <= gx_d;
            gy_q         <= gy_d;
            g_vld_q      <= g_vld_d;
            out_pix_q    <= out_pix_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_sobel_stream_core.sv
// Directed bench for sobel_stream_core on an 8x4 image with 8-bit pixels.
module tb_sobel_stream_core;

    localparam int W    = 8;
    localparam int H    = 4;
    localparam int NPIX = W * H;
    localparam int NOUT = (W - 2) * (H - 2);

    logic       clk = 1'b0;
    logic       n_rst, start, in_valid, in_ready, out_valid, out_ready, busy, frame_done;
    logic [7:0] in_pix, out_pix, thresh;

    always #5 clk = ~clk;

    sobel_stream_core #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start),
        .in_pix     (in_pix),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_pix    (out_pix),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
`ifdef SOBEL_THRESH_EN
        .thresh     (thresh),
`endif
        .busy       (busy),
        .frame_done (frame_done)
    );

    typedef struct {
        logic [7:0] lo;
        logic [7:0] hi;
        int         dc;
        int         dr;
        logic [7:0] thr;
        logic [7:0] exp_row [6];
    } vec_t;

    vec_t       tbl [6];
    logic [7:0] img [NPIX];
    logic [7:0] exp_out [NOUT];
    logic [7:0] got [$];
    int         fd_cnt = 0;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid && out_ready) got.push_back(out_pix);
        if (frame_done) fd_cnt = fd_cnt + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_vec(input int k, input int lo, input int hi, input int dc, input int dr,
                           input int thr, input int e0, input int e1, input int e2,
                           input int e3, input int e4, input int e5);
        tbl[k].lo = 8'(lo); tbl[k].hi = 8'(hi); tbl[k].dc = dc; tbl[k].dr = dr;
        tbl[k].thr = 8'(thr);
        tbl[k].exp_row[0] = 8'(e0); tbl[k].exp_row[1] = 8'(e1); tbl[k].exp_row[2] = 8'(e2);
        tbl[k].exp_row[3] = 8'(e3); tbl[k].exp_row[4] = 8'(e4); tbl[k].exp_row[5] = 8'(e5);
    endtask

    task automatic build_img(input int lo, input int hi, input int dc, input int dr);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r*W+c] = 8'(((c < 4) ? lo : hi) + dc * c + dr * r);
    endtask

    function automatic int px(input int r, input int c);
        return int'(img[r*W+c]);
    endfunction

    // Plain frame-level Sobel over img, used for the random-image run.
    task automatic model_fill;
        int gx, gy, m;
        for (int r = 1; r < H - 1; r++) begin
            for (int c = 1; c < W - 1; c++) begin
                gx = (px(r-1,c+1) + 2*px(r,c+1) + px(r+1,c+1)) - (px(r-1,c-1) + 2*px(r,c-1) + px(r+1,c-1));
                gy = (px(r+1,c-1) + 2*px(r+1,c) + px(r+1,c+1)) - (px(r-1,c-1) + 2*px(r-1,c) + px(r-1,c+1));
                m = ((gx < 0) ? -gx : gx) + ((gy < 0) ? -gy : gy);
                if (m > 255) m = 255;
`ifdef SOBEL_THRESH_EN
                m = (m >= int'(thresh)) ? 255 : 0;
`endif
                exp_out[(r-1)*(W-2) + (c-1)] = 8'(m);
            end
        end
    endtask

    task automatic pulse_start;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic drive(input bit rnd, input bit stall, output int acc18, output int used, output int fv);
        int idx = 0;
        int cycles = 0;
        int stall_left = 0;
        bit stalled = 1'b0;
        bit hs;
        logic [7:0] held = 8'd0;
        acc18 = -100;
        fv = -1;
        while (idx < NPIX && cycles < 2000) begin
            in_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_pix   = img[idx];
            if (stall && !stalled && idx >= 21 && out_valid) begin
                stalled = 1'b1;
                stall_left = 5;
                held = out_pix;
            end
            out_ready = (stall_left == 0);
            @(negedge clk);
            if (out_valid && fv < 0) fv = cyc;
            if (stall_left > 0) begin
                check("stall_in_ready", int'(in_ready), 0);
                check("stall_out_valid", int'(out_valid), 1);
                check("stall_hold", int'(out_pix), int'(held));
                stall_left--;
            end
            hs = in_valid && in_ready;
            @(posedge clk); #1;
            if (hs) begin
                if (idx == 18) acc18 = cyc;
                idx++;
            end
            cycles++;
        end
        check("all_pixels_accepted", idx, NPIX);
        if (stall) check("stall_happened", int'(stalled), 1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        used = cycles;
    endtask

    task automatic run_frame(input bit rnd, input bit stall, input bit timing);
        int ob, fb, acc18, used, fv, n;
        ob = got.size();
        fb = fd_cnt;
        pulse_start();
        check("busy_in_run", int'(busy), 1);
        drive(rnd, stall, acc18, used, fv);
        n = 0;
        while (fd_cnt == fb && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("frame_done_pulses", fd_cnt - fb, 1);
        check("busy_after_frame", int'(busy), 0);
        check("out_count", got.size() - ob, NOUT);
        for (int i = 0; i < NOUT; i++)
            check($sformatf("pix%0d", i), (ob + i < got.size()) ? int'(got[ob+i]) : -1, int'(exp_out[i]));
        if (timing) begin
            check("latency", fv - acc18, 2);
            check("throughput_cycles", used, NPIX);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1);
    end

    initial begin
`ifdef SOBEL_THRESH_EN
        set_vec(0, 100, 100,  0,  0,  30,   0,   0,   0,   0,   0,   0);
        set_vec(1,  10,  20,  0,  0,  30,   0,   0, 255, 255,   0,   0);
        set_vec(2,   0, 255,  0,  0, 255,   0,   0, 255, 255,   0,   0);
        set_vec(3,  60,  50,  0,  0,  41,   0,   0,   0,   0,   0,   0);
        set_vec(4,   0,   0, 10, 20, 240, 255, 255, 255, 255, 255, 255);
        set_vec(5,   0,   0, 30, 10, 241, 255, 255, 255, 255, 255, 255);
`else
        set_vec(0, 100, 100,  0,  0,   0,   0,   0,   0,   0,   0,   0);
        set_vec(1,  10,  20,  0,  0,   0,   0,   0,  40,  40,   0,   0);
        set_vec(2,   0, 255,  0,  0,   0,   0,   0, 255, 255,   0,   0);
        set_vec(3,  60,  50,  0,  0,   0,   0,   0,  40,  40,   0,   0);
        set_vec(4,   0,   0, 10, 20,   0, 240, 240, 240, 240, 240, 240);
        set_vec(5,   0,   0, 30, 10,   0, 255, 255, 255, 255, 255, 255);
`endif
        n_rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_pix = 8'd0;
        out_ready = 1'b1; thresh = 8'd0;
        #1;
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_pix", int'(out_pix), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_frame_done", int'(frame_done), 0);
        repeat (3) @(posedge clk);
        #1 n_rst = 1'b1;

        for (int k = 0; k < 6; k++) begin
            build_img(int'(tbl[k].lo), int'(tbl[k].hi), tbl[k].dc, tbl[k].dr);
            thresh = tbl[k].thr;
            for (int i = 0; i < NOUT; i++) exp_out[i] = tbl[k].exp_row[i % (W-2)];
            run_frame(1'b0, 1'b0, 1'b1);
        end

        // Random image, bursty input, 5-cycle output stall mid-frame.
        for (int i = 0; i < NPIX; i++) img[i] = 8'($urandom_range(0, 255));
        thresh = 8'd100;
        model_fill();
        run_frame(1'b1, 1'b1, 1'b0);

        // Reset after 15 accepted pixels abandons the frame.
        begin
            int fb, acc;
            build_img(100, 100, 0, 0);
            thresh = 8'd30;
            fb = fd_cnt;
            pulse_start();
            in_valid = 1'b1;
            in_pix   = 8'd100;
            repeat (15) @(posedge clk);
            #1 n_rst = 1'b0;
            in_valid = 1'b0;
            #1;
            check("mid_rst_in_ready", int'(in_ready), 0);
            check("mid_rst_out_valid", int'(out_valid), 0);
            check("mid_rst_out_pix", int'(out_pix), 0);
            check("mid_rst_busy", int'(busy), 0);
            check("mid_rst_frame_done", int'(frame_done), 0);
            @(posedge clk); #1 n_rst = 1'b1;
            in_valid = 1'b1;
            acc = 0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (in_valid && in_ready) acc++;
            end
            in_valid = 1'b0;
            check("no_accept_without_start", acc, 0);
            check("no_frame_done_after_rst", fd_cnt - fb, 0);
            for (int i = 0; i < NOUT; i++) exp_out[i] = 8'd0;
            run_frame(1'b0, 1'b0, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
